// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the two-requester SPI transfer arbiter:
// register map, STATUS bit positions and FSM state encoding.
package spi_xfer_pkg;

    localparam logic [2:0] REG_RXDATA  = 3'd0;
    localparam logic [2:0] REG_TXDATA  = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_SSMASK  = 3'd4;

    localparam int STAT_TMT  = 5;
    localparam int STAT_TRDY = 6;
    localparam int STAT_RRDY = 7;

    typedef enum logic [3:0] {
        ST_CFG,
        ST_IDLE,
        ST_SEL,
        ST_PT,
        ST_PTW,
        ST_TX,
        ST_PR,
        ST_PRW,
        ST_RD,
        ST_RDW,
        ST_FIN
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that did not win last time (requester 0 before any win).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       last_valid,
    output logic [1:0] grant
);

    logic favour;

    always_comb begin
        favour = last_valid ? ~last : 1'b0;
        grant  = 2'b00;
        if (req == 2'b11) begin
            grant = favour ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master register port between two byte-transfer requesters:
// configures the IP once, then runs select / TX / poll / RX sequences per grant.
module spi_xfer_arbiter
    import spi_xfer_pkg::*;
#(
    parameter int            DW       = 8,
    parameter logic [DW-1:0] CTRL_VAL = '0,
    parameter int            TMO_W    = 16
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic [1:0]    req,
    input  logic [DW-1:0] txd0,
    input  logic [DW-1:0] txd1,
    input  logic [2:0]    ss_sel0,
    input  logic [2:0]    ss_sel1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          err,
    output logic [DW-1:0] rxd,
    output logic          busy,
    output logic          tx_en,
    output logic          rx_en,
    output logic [2:0]    waddr,
    output logic [2:0]    raddr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata
);

    // The final permitted miss is seen when the counter already holds max-1.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t          state;
    state_t          next_state;
    logic [TMO_W-1:0] poll_cnt;
    logic            tmo_q;
    logic [1:0]      gnt_q;
    logic            rr_last;
    logic            rr_valid;
    logic            cfg_done;
    logic [DW-1:0]   tx_byte;
    logic [2:0]      ss_q;
    logic [DW-1:0]   rxd_q;
    logic [1:0]      arb_grant;

    rr_arb2 u_arb (
        .req        (req),
        .last       (rr_last),
        .last_valid (rr_valid),
        .grant      (arb_grant)
    );

    always_comb begin
        next_state = state;
        tx_en      = 1'b0;
        rx_en      = 1'b0;
        waddr      = '0;
        raddr      = '0;
        wdata      = '0;
        done       = '0;
        err        = 1'b0;
        busy       = 1'b0;

        case (state)
            ST_CFG:  next_state = ST_IDLE;
            ST_IDLE: if (cfg_done && (req != 2'b00)) next_state = ST_SEL;
            ST_SEL:  next_state = ST_PT;
            ST_PT:   next_state = ST_PTW;
            ST_PTW: begin
                if (rdata[STAT_TRDY])        next_state = ST_TX;
                else if (poll_cnt == TMO_LAST) next_state = ST_FIN;
                else                         next_state = ST_PT;
            end
            ST_TX:   next_state = ST_PR;
            ST_PR:   next_state = ST_PRW;
            ST_PRW: begin
                if (rdata[STAT_RRDY])        next_state = ST_RD;
                else if (poll_cnt == TMO_LAST) next_state = ST_FIN;
                else                         next_state = ST_PR;
            end
            ST_RD:   next_state = ST_RDW;
            ST_RDW:  next_state = ST_FIN;
            ST_FIN:  next_state = ST_IDLE;
            default: next_state = ST_CFG;
        endcase

        // Port strobes are decoded from state; reset forces everything quiet.
        if (!I_RST) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_CFG: begin
                    tx_en = 1'b1;
                    waddr = REG_CONTROL;
                    wdata = CTRL_VAL;
                end
                ST_SEL: begin
                    tx_en = 1'b1;
                    waddr = REG_SSMASK;
                    wdata = DW'(1) << ss_q;
                end
                ST_PT, ST_PR: begin
                    rx_en = 1'b1;
                    raddr = REG_STATUS;
                end
                ST_TX: begin
                    tx_en = 1'b1;
                    waddr = REG_TXDATA;
                    wdata = tx_byte;
                end
                ST_RD: begin
                    rx_en = 1'b1;
                    raddr = REG_RXDATA;
                end
                ST_FIN: begin
                    done = gnt_q;
                    err  = tmo_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state    <= ST_CFG;
            poll_cnt <= '0;
            tmo_q    <= 1'b0;
            gnt_q    <= 2'b00;
            rr_last  <= 1'b0;
            rr_valid <= 1'b0;
            cfg_done <= 1'b0;
            tx_byte  <= '0;
            ss_q     <= '0;
            rxd_q    <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_CFG: cfg_done <= 1'b1;
                ST_IDLE: begin
                    if (next_state == ST_SEL) begin
                        gnt_q   <= arb_grant;
                        tx_byte <= arb_grant[1] ? txd1 : txd0;
                        ss_q    <= arb_grant[1] ? ss_sel1 : ss_sel0;
                        tmo_q   <= 1'b0;
                    end
                end
                ST_SEL, ST_TX: poll_cnt <= '0;
                ST_PTW, ST_PRW: begin
                    if (next_state == ST_FIN) begin
                        tmo_q <= 1'b1;
                    end else if ((next_state == ST_PT) || (next_state == ST_PR)) begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                ST_RDW: rxd_q <= rdata;
                ST_FIN: begin
                    gnt_q    <= 2'b00;
                    rr_last  <= gnt_q[1];
                    rr_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt = gnt_q;
    assign rxd = rxd_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: table vectors, randomized transfers
// against a poll-count model, reset corner cases and a per-cycle strobe monitor.
module tb_spi_xfer_arbiter;

    localparam int          DW        = 8;
    localparam logic [7:0]  CTRL      = 8'hC5;
    localparam int          TMO_W     = 4;
    localparam int          TMO_POLLS = (1 << TMO_W) - 1;

    typedef struct {
        logic [1:0] req;
        logic [7:0] txd0;
        logic [7:0] txd1;
        logic [2:0] ss0;
        logic [2:0] ss1;
        int         ta;
        int         ra;
        logic [7:0] rxv;
        bit         hold;
        bit         dropReq;
        logic [1:0] expGnt;
        int         expLat;
        logic       expErr;
        logic [7:0] expRxd;
    } vec_t;

    logic          I_CLK = 1'b0;
    logic          I_RST = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [7:0]    txd0 = '0;
    logic [7:0]    txd1 = '0;
    logic [2:0]    ss_sel0 = '0;
    logic [2:0]    ss_sel1 = '0;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          err;
    logic [7:0]    rxd;
    logic          busy;
    logic          tx_en;
    logic          rx_en;
    logic [2:0]    waddr;
    logic [2:0]    raddr;
    logic [7:0]    wdata;
    logic [7:0]    rdata = '0;

    int checks = 0;
    int errors = 0;

    int         ipTrdyAfter = 0;
    int         ipRrdyAfter = 0;
    logic [7:0] ipRxVal = '0;
    int         pollCnt = 0;
    bit         txPhase = 1'b0;
    logic [10:0] wrLog[$];
    int         wrPtr = 0;

    int         lastWinner = -1;
    logic [7:0] rxdModel = '0;

    spi_xfer_arbiter #(
        .DW       (DW),
        .CTRL_VAL (CTRL),
        .TMO_W    (TMO_W)
    ) dut (
        .I_CLK   (I_CLK),
        .I_RST   (I_RST),
        .req     (req),
        .txd0    (txd0),
        .txd1    (txd1),
        .ss_sel0 (ss_sel0),
        .ss_sel1 (ss_sel1),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .rxd     (rxd),
        .busy    (busy),
        .tx_en   (tx_en),
        .rx_en   (rx_en),
        .waddr   (waddr),
        .raddr   (raddr),
        .wdata   (wdata),
        .rdata   (rdata)
    );

    always #5 I_CLK = ~I_CLK;

    // Behavioural IP: STATUS reports the opposite flag as set so a wrong bit
    // choice is caught; outside read responses rdata carries random junk.
    logic trdyNow;
    logic rrdyNow;
    assign trdyNow = (pollCnt >= ipTrdyAfter);
    assign rrdyNow = (pollCnt >= ipRrdyAfter);

    always @(posedge I_CLK) begin
        if (tx_en) begin
            wrLog.push_back({waddr, wdata});
            if (waddr == 3'd4) begin
                txPhase <= 1'b0;
                pollCnt <= 0;
            end
            if (waddr == 3'd1) begin
                txPhase <= 1'b1;
                pollCnt <= 0;
            end
        end
        if (rx_en && raddr == 3'd2) begin
            pollCnt <= pollCnt + 1;
            if (!txPhase) rdata <= {~trdyNow, trdyNow, 1'b1, 5'b0};
            else          rdata <= {rrdyNow, ~rrdyNow, 1'b1, 5'b0};
        end else if (rx_en && raddr == 3'd0) begin
            rdata <= ipRxVal;
        end else begin
            rdata <= 8'($urandom);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge I_CLK);
        checkOutput("strobe_excl", 32'(tx_en & rx_en), 0);
        checkOutput("gnt_onehot", 32'($countones(gnt) > 1), 0);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_gnt"}, gnt, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_rxd"}, rxd, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_tx_en"}, tx_en, 0);
        checkOutput({tag, "_rx_en"}, rx_en, 0);
        checkOutput({tag, "_waddr"}, waddr, 0);
        checkOutput({tag, "_raddr"}, raddr, 0);
        checkOutput({tag, "_wdata"}, wdata, 0);
    endtask

    task automatic doReset();
        I_RST = 1'b1;
        req   = 2'b00;
        tick();
        checkQuiet("rst");
        tick();
        checkOutput("rst_done2", done, 0);
        I_RST = 1'b0;
        #1;
        checkOutput("cfg_tx_en", tx_en, 1);
        checkOutput("cfg_waddr", waddr, 3);
        checkOutput("cfg_wdata", wdata, CTRL);
        checkOutput("cfg_rx_en", rx_en, 0);
        wrPtr = wrLog.size();
        tick();
        checkOutput("idle_busy", busy, 0);
        checkOutput("cfg_wr_count", wrLog.size() - wrPtr, 1);
        if (wrLog.size() > wrPtr) checkOutput("cfg_wr", wrLog[wrPtr], {3'd3, CTRL});
        wrPtr = wrLog.size();
        lastWinner = -1;
        rxdModel   = '0;
    endtask

    // Reference timing: each poll costs two cycles; a run of TMO_POLLS misses ends the transfer.
    function automatic void xferModel(input int ta, input int ra, output int lat, output logic e);
        if (ta >= TMO_POLLS) begin
            lat = 1 + 2 * TMO_POLLS + 1;
            e   = 1'b1;
        end else if (ra >= TMO_POLLS) begin
            lat = 1 + 2 * (ta + 1) + 1 + 2 * TMO_POLLS + 1;
            e   = 1'b1;
        end else begin
            lat = 1 + 2 * (ta + 1) + 1 + 2 * (ra + 1) + 2 + 1;
            e   = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        int         n;
        int         w;
        int         expWr;
        bit         seen;
        logic [7:0] expByte;
        logic [7:0] mask;
        w       = v.expGnt[1] ? 1 : 0;
        expByte = w ? v.txd1 : v.txd0;
        mask    = 8'd1 << (w ? v.ss1 : v.ss0);
        expWr   = (v.ta >= TMO_POLLS) ? 1 : 2;
        req     = v.req;
        txd0    = v.txd0;
        txd1    = v.txd1;
        ss_sel0 = v.ss0;
        ss_sel1 = v.ss1;
        ipTrdyAfter = v.ta;
        ipRrdyAfter = v.ra;
        ipRxVal     = v.rxv;
        wrPtr = wrLog.size();
        n    = 0;
        seen = 1'b0;
        while (!seen && n < v.expLat + 40) begin
            tick();
            n++;
            if (n == 1) begin
                checkOutput("gnt_at_grant", gnt, v.expGnt);
                checkOutput("busy_xfer", busy, 1);
                txd0    = 8'($urandom);
                txd1    = 8'($urandom);
                ss_sel0 = 3'($urandom);
                ss_sel1 = 3'($urandom);
            end
            if (n == 2 && v.dropReq) req = 2'b00;
            if (done != 2'b00) seen = 1'b1;
            else if (gnt !== v.expGnt) checkOutput("gnt_hold", gnt, v.expGnt);
        end
        if (!seen) begin
            checkOutput("done_seen", 0, 1);
        end else begin
            checkOutput("latency", n, v.expLat);
            checkOutput("done", done, v.expGnt);
            checkOutput("gnt_in_done", gnt, v.expGnt);
            checkOutput("err", err, v.expErr);
            checkOutput("rxd", rxd, v.expRxd);
            checkOutput("wr_count", wrLog.size() - wrPtr, expWr);
            if (wrLog.size() > wrPtr) checkOutput("wr_ssmask", wrLog[wrPtr], {3'd4, mask});
            if (expWr == 2 && wrLog.size() > wrPtr + 1)
                checkOutput("wr_txdata", wrLog[wrPtr + 1], {3'd1, expByte});
        end
        if (!v.hold) req = 2'b00;
        tick();
        checkOutput("gnt_after", gnt, 0);
        checkOutput("done_after", done, 0);
        checkOutput("busy_after", busy, 0);
        wrPtr      = wrLog.size();
        lastWinner = w;
        if (!v.expErr) rxdModel = v.rxv;
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        int   w;
        vecs[0] = '{2'b11, 8'h11, 8'h22, 3'd0, 3'd1, 0,  0,  8'hA1, 1, 0, 2'b01, 9,  1'b0, 8'hA1};
        vecs[1] = '{2'b11, 8'h33, 8'h44, 3'd2, 3'd3, 1,  0,  8'hB2, 1, 0, 2'b10, 11, 1'b0, 8'hB2};
        vecs[2] = '{2'b11, 8'h55, 8'h66, 3'd4, 3'd5, 0,  2,  8'hC3, 1, 0, 2'b01, 13, 1'b0, 8'hC3};
        vecs[3] = '{2'b11, 8'h77, 8'h88, 3'd6, 3'd7, 2,  3,  8'hD4, 0, 0, 2'b10, 19, 1'b0, 8'hD4};
        vecs[4] = '{2'b01, 8'hE3, 8'h00, 3'd2, 3'd0, 0,  0,  8'h5A, 0, 0, 2'b01, 9,  1'b0, 8'h5A};
        vecs[5] = '{2'b10, 8'h00, 8'h3C, 3'd0, 3'd7, 3,  1,  8'h99, 0, 0, 2'b10, 17, 1'b0, 8'h99};
        vecs[6] = '{2'b11, 8'hF0, 8'h0F, 3'd1, 3'd2, 0,  20, 8'h77, 0, 0, 2'b01, 35, 1'b1, 8'h99};
        vecs[7] = '{2'b11, 8'hAB, 8'hCD, 3'd3, 3'd5, 20, 0,  8'h66, 0, 0, 2'b10, 32, 1'b1, 8'h99};
        vecs[8] = '{2'b01, 8'h81, 8'h18, 3'd7, 3'd0, 1,  1,  8'h42, 0, 1, 2'b01, 13, 1'b0, 8'h42};

        @(negedge I_CLK);
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        for (int i = 0; i < 12; i++) begin
            v.req     = 2'($urandom_range(1, 3));
            v.txd0    = 8'($urandom);
            v.txd1    = 8'($urandom);
            v.ss0     = 3'($urandom);
            v.ss1     = 3'($urandom);
            v.ta      = $urandom_range(0, 3);
            v.ra      = ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, 3);
            v.rxv     = 8'($urandom);
            v.hold    = 0;
            v.dropReq = $urandom_range(0, 1);
            if (v.req == 2'b01)      w = 0;
            else if (v.req == 2'b10) w = 1;
            else                     w = (lastWinner == 0) ? 1 : 0;
            v.expGnt = 2'b01 << w;
            xferModel(v.ta, v.ra, v.expLat, v.expErr);
            v.expRxd = v.expErr ? rxdModel : v.rxv;
            applyStimulus(v);
        end

        // Abort a transfer while it is polling for RRDY.
        req = 2'b10;
        txd1 = 8'h5C;
        ss_sel1 = 3'd3;
        ipTrdyAfter = 0;
        ipRrdyAfter = 5;
        for (int n = 0; n < 5; n++) tick();
        checkOutput("pr_rx_en", rx_en, 1);
        checkOutput("pr_raddr", raddr, 2);
        doReset();

        v = '{2'b11, 8'h12, 8'h34, 3'd1, 3'd6, 0, 1, 8'h3E, 0, 0, 2'b01, 11, 1'b0, 8'h3E};
        applyStimulus(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
